// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port (CPU/DMA) arbiter for a shared single-command RAM port
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (round-robin in IDLE; fixed CPU priority when undefined)
module ram_arbiter #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DWIDTH-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [AWIDTH-1:0] dma_addr,
    input  logic [DWIDTH-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DWIDTH-1:0] dma_rdata,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [AWIDTH-1:0] ram_raddr,
    output logic [AWIDTH-1:0] ram_waddr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata
);

    typedef enum logic {
        IDLE    = 1'b0,
        OWN_DMA = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] lock_cnt;
    logic [3:0] lock_cnt_nxt;
    logic       rd_pend_cpu;
    logic       rd_pend_dma;
    logic       force_cpu;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // 1 when DMA was the most recent port granted
    logic       last_dma;
`endif

    // Locked DMA has had 15 consecutive cycles: this cycle is opened up to the CPU
    assign force_cpu = (state == OWN_DMA) && dma_lock && (lock_cnt == 4'd15);

    // Grant selection and next-state; reset blanks all grants
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        cpu_gnt      = 1'b0;
        dma_gnt      = 1'b0;
        if (rst) begin
            state_nxt    = IDLE;
            lock_cnt_nxt = 4'd0;
        end else if ((state == OWN_DMA) && dma_lock && !force_cpu) begin
            dma_gnt      = dma_req;
            lock_cnt_nxt = lock_cnt + 4'd1;
            state_nxt    = OWN_DMA;
        end else if (force_cpu) begin
            // One-cycle window with CPU priority; the lock is still held so ownership resumes
            cpu_gnt      = cpu_req;
            dma_gnt      = dma_req & ~cpu_req;
            lock_cnt_nxt = 4'd0;
            state_nxt    = OWN_DMA;
        end else begin
            lock_cnt_nxt = 4'd0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            if (cpu_req && dma_req) begin
                cpu_gnt = last_dma;
                dma_gnt = ~last_dma;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req;
            end
`else
            cpu_gnt = cpu_req;
            dma_gnt = dma_req & ~cpu_req;
`endif
            state_nxt = (dma_gnt && dma_lock) ? OWN_DMA : IDLE;
        end
    end

    // Granted port's command goes straight to the RAM in the same cycle
    always_comb begin
        ram_rd    = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
        ram_wr    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
        ram_raddr = dma_gnt ? dma_addr : cpu_addr;
        ram_waddr = dma_gnt ? dma_addr : cpu_addr;
        ram_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    end

    // Read data returns one cycle later; reset in that cycle swallows it
    always_comb begin
        cpu_rvalid = rd_pend_cpu & ~rst;
        dma_rvalid = rd_pend_dma & ~rst;
        cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
        dma_rdata  = dma_rvalid ? ram_rdata : '0;
    end

    // FSM state, lock counter and pending-read tags
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lock_cnt    <= 4'd0;
            rd_pend_cpu <= 1'b0;
            rd_pend_dma <= 1'b0;
        end else begin
            state       <= state_nxt;
            lock_cnt    <= lock_cnt_nxt;
            rd_pend_cpu <= cpu_gnt & ~cpu_we;
            rd_pend_dma <= dma_gnt & ~dma_we;
        end
    end

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Last-winner pointer moves only when somebody is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            last_dma <= 1'b0;
        end else if (cpu_gnt || dma_gnt) begin
            last_dma <= dma_gnt;
        end
    end
`endif

endmodule
